// File: rtl/onehot_select_seq_pkg.sv
// Shared definitions for the one-hot select generator and the control unit
// that drives its mode input.
package onehot_select_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_DECODE = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_STEP   = 2'b11
  } mode_e;

endpackage

// File: rtl/onehot_select_seq_if.sv
// Control/status bundle of the one-hot select generator.
interface onehot_select_seq_if #(
  parameter int SEL_W   = 3,
  parameter int N_OUT   = 8,
  parameter int DWELL_W = 8
);
  logic               en;
  logic [1:0]         mode;
  logic [SEL_W-1:0]   sel;
  logic               step;
  logic [DWELL_W-1:0] dwell;
  logic [N_OUT-1:0]   y;
  logic [SEL_W-1:0]   idx;
  logic               valid;
  logic               wrap;

  modport master (
    output en, mode, sel, step, dwell,
    input  y, idx, valid, wrap
  );

  modport slave (
    input  en, mode, sel, step, dwell,
    output y, idx, valid, wrap
  );
endinterface

// File: rtl/onehot_select_seq_dec.sv
// Combinational binary-to-one-hot decoder with an in-range flag.
// Indices at or above N_OUT give an all-zero output and hit=0.
module onehot_dec #(
  parameter int SEL_W = 3,
  parameter int N_OUT = 8
) (
  input  logic [SEL_W-1:0] idx,
  output logic [N_OUT-1:0] y,
  output logic             hit
);

  // One output bit per legal index; nothing set when out of range.
  always_comb begin
    y   = '0;
    hit = 1'b0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (idx == SEL_W'(k)) begin
        y[k] = 1'b1;
        hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/onehot_select_seq.sv
// Registered one-hot select generator: DECODE, free-running SCAN with
// programmable dwell, and single-STEP modes with index/valid/wrap status.
module onehot_select_seq
  import onehot_select_seq_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int N_OUT   = 8,
  parameter int DWELL_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  onehot_select_seq_if.slave  bus
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_OUT - 1);

  mode_e              state_q, state_d, mode_in;
  logic [SEL_W-1:0]   idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               wrap_d, out_en, adv;
  logic [N_OUT-1:0]   dec_y;
  logic               dec_hit;

  assign mode_in = mode_e'(bus.mode);

  // The decoder sees the index being loaded this edge, so y/valid are the
  // registered decode of the new idx rather than of the old one.
  onehot_dec #(
    .SEL_W (SEL_W),
    .N_OUT (N_OUT)
  ) u_dec (
    .idx (idx_d),
    .y   (dec_y),
    .hit (dec_hit)
  );

  // Next-state, next-index, dwell counter and wrap decision.
  always_comb begin
    state_d = mode_in;
    idx_d   = bus.idx;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    out_en  = 1'b0;
    adv     = 1'b0;
    case (mode_in)
      MODE_OFF: ;
      MODE_DECODE: begin
        idx_d  = bus.sel;
        out_en = 1'b1;
      end
      MODE_SCAN, MODE_STEP: begin
        out_en = 1'b1;
        if (state_q != mode_in) begin
          idx_d = '0;
          cnt_d = bus.dwell;
        end else if (mode_in == MODE_SCAN) begin
          if (cnt_q == '0) begin
            adv   = 1'b1;
            cnt_d = bus.dwell;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end else begin
          adv = bus.step;
        end
        if (adv) begin
          wrap_d = (bus.idx == LAST);
          idx_d  = wrap_d ? '0 : bus.idx + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // All state and outputs; en=0 freezes everything except wrap, which drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MODE_OFF;
      cnt_q     <= '0;
      bus.idx   <= '0;
      bus.y     <= '0;
      bus.valid <= 1'b0;
      bus.wrap  <= 1'b0;
    end else if (bus.en) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus.idx   <= idx_d;
      bus.y     <= out_en ? dec_y : '0;
      bus.valid <= out_en & dec_hit;
      bus.wrap  <= wrap_d;
    end else begin
      bus.wrap  <= 1'b0;
    end
  end

endmodule
